// File: rtl/div_unit_if.sv
// div_unit_if: handshake/result bundle between the multicycle control unit
// (master) and the signed divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             DivOp;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             div_busy;
  logic             div_end;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output DivOp, dividend, divisor,
    input  div_busy, div_end, div_zero, hi_out, lo_out
  );

  modport slave (
    input  DivOp, dividend, divisor,
    output div_busy, div_end, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multicycle signed restoring divider. Quotient to lo_out,
// remainder to hi_out, truncating semantics (remainder takes the dividend's
// sign). One restoring step per cycle on magnitudes, sign fix-up in FIX.
// Optional feature macro: DIV_ZERO_EXC_EN -- a zero divisor is rejected in
// IDLE with a one-cycle div_zero pulse; otherwise div_zero is tied low and a
// zero divisor runs the normal sequence.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_in,
  div_unit_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             end_q, end_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             div_by_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

`ifdef DIV_ZERO_EXC_EN
  assign div_by_zero = (bus.divisor == '0);
`else
  assign div_by_zero = 1'b0;
`endif

  // Next-state and datapath: operand capture, restoring step, sign fix-up.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    zero_d    = 1'b0;

    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (bus.DivOp) begin
          if (div_by_zero) begin
            zero_d = 1'b1;
          end else begin
            quo_d     = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
            dvs_d     = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
            neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_rem_d = bus.dividend[WIDTH-1];
            rem_d     = '0;
            count_d   = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy stays up through the div_end cycle so it drops together with it.
    end_d  = (state_q == FIX);
    busy_d = (state_d != IDLE) || (state_q == FIX);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      end_q     <= end_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.div_busy = busy_q;
  assign bus.div_end  = end_q;
  assign bus.div_zero = zero_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, table-driven bench for div_unit (WIDTH=32).
// Honours DIV_ZERO_EXC_EN to select the zero-divisor expectations.
module tb_div_unit;

  logic clk;
  logic reset_in;
  int   checks;
  int   errors;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Present a start for one edge; returns #1 after the accepting edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.DivOp    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.DivOp = 1'b0;
  endtask

  // Wait (bounded) for div_end, check latency and results; optionally check
  // the following edge drops div_end and div_busy.
  task automatic wait_result(input string name, input int exp_lat,
                             input logic [31:0] q, input logic [31:0] r,
                             input bit tail);
    int lat;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_end) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      chk({name, "_lo"}, bus.lo_out, q);
      chk({name, "_hi"}, bus.hi_out, r);
      chk({name, "_busy_at_end"}, {31'b0, bus.div_busy}, 32'd1);
      chk({name, "_zero"}, {31'b0, bus.div_zero}, 32'd0);
      if (tail) begin
        @(posedge clk);
        #1;
        chk({name, "_end_drop"}, {31'b0, bus.div_end}, 32'd0);
        chk({name, "_busy_drop"}, {31'b0, bus.div_busy}, 32'd0);
      end
    end
  endtask

  initial begin
    int no_end;
    checks = 0;
    errors = 0;

    vecs[0] = '{32'd7,          32'd2,          32'd3,          32'd1};
    vecs[1] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2] = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    vecs[3] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[4] = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[5] = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
    vecs[6] = '{32'd0,          32'd5,          32'd0,          32'd0};
    vecs[7] = '{32'hFFFFFFFF,   32'h80000000,   32'd0,          32'hFFFFFFFF};
    vecs[8] = '{32'h80000000,   32'h80000000,   32'd1,          32'd0};
    vecs[9] = '{32'd1000,       32'hFFFFFFDF,   32'hFFFFFFE2,   32'd10};

    bus.DivOp    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset_in     = 1'b0;
    #12;
    chk("rst_busy", {31'b0, bus.div_busy}, 32'd0);
    chk("rst_end",  {31'b0, bus.div_end},  32'd0);
    chk("rst_zero", {31'b0, bus.div_zero}, 32'd0);
    chk("rst_lo",   bus.lo_out, 32'd0);
    chk("rst_hi",   bus.hi_out, 32'd0);
    @(negedge clk);
    reset_in = 1'b1;

    // Table-driven main function.
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_start", i), {31'b0, bus.div_busy}, 32'd1);
      wait_result($sformatf("v%0d", i), 33, vecs[i].q, vecs[i].r, 1'b1);
    end

    // Zero divisor; prior result is 1000 / -33.
`ifdef DIV_ZERO_EXC_EN
    start(32'd5, 32'd0);
    chk("dz_pulse", {31'b0, bus.div_zero}, 32'd1);
    chk("dz_busy",  {31'b0, bus.div_busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("dz_pulse_one_cycle", {31'b0, bus.div_zero}, 32'd0);
    no_end = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_end || bus.div_busy) no_end++;
    end
    chk("dz_no_activity", 32'(no_end), 32'd0);
    chk("dz_lo_hold", bus.lo_out, 32'hFFFFFFE2);
    chk("dz_hi_hold", bus.hi_out, 32'd10);
`else
    start(32'd5, 32'd0);
    chk("dz_busy", {31'b0, bus.div_busy}, 32'd1);
    wait_result("dz", 33, 32'hFFFFFFFF, 32'd5, 1'b1);
`endif

    // Start re-pulsed at N+10 with new operands must be ignored.
    start(32'd7, 32'd2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.DivOp    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    #1;
    bus.DivOp = 1'b0;
    wait_result("ignore", 23, 32'd3, 32'd1, 1'b1);

    // Back-to-back: new start during the div_end cycle.
    start(32'd9, 32'd4);
    wait_result("b2b_first", 33, 32'd2, 32'd1, 1'b0);
    start(32'hFFFFFFF7, 32'd4);
    chk("b2b_busy_held", {31'b0, bus.div_busy}, 32'd1);
    chk("b2b_end_drop",  {31'b0, bus.div_end},  32'd0);
    wait_result("b2b_second", 33, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1);

    // Asynchronous reset mid-RUN.
    start(32'd7, 32'd2);
    repeat (10) @(posedge clk);
    #3;
    reset_in = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, bus.div_busy}, 32'd0);
    chk("mid_rst_end",  {31'b0, bus.div_end},  32'd0);
    chk("mid_rst_zero", {31'b0, bus.div_zero}, 32'd0);
    chk("mid_rst_lo",   bus.lo_out, 32'd0);
    chk("mid_rst_hi",   bus.hi_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_in = 1'b1;
    no_end = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_end) no_end++;
    end
    chk("mid_rst_no_end", 32'(no_end), 32'd0);
    start(32'd100, 32'd7);
    wait_result("after_rst", 33, 32'd14, 32'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multicycle signed 32-bit divider driven by the multicycle control unit's `DivOp` strobe. It produces the quotient for LO and the remainder for HI, and flags division by zero for the exception path. The divider sits on the datapath between the A/B operand registers and the HI/LO registers. The control unit holds in its wait state until `div_end` or `div_zero` pulses, then asserts `HI_reg_w`/`LO_reg_w` or routes to the exception handler. DIVM operand fetch (`DivmOp`) is resolved upstream; this block only sees the final operands.

## Interface
Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_in` input 1: reset, asynchronous, active-low.
- `DivOp` input 1: start strobe; sampled only in IDLE.
- `dividend` input WIDTH: signed dividend (A register); sampled with `DivOp`.
- `divisor` input WIDTH: signed divisor (B register); sampled with `DivOp`.
- `div_busy` output 1: high in RUN and FIX.
- `div_end` output 1: one-cycle pulse when `hi_out`/`lo_out` hold a new result.
- `div_zero` output 1: one-cycle pulse when a divide by zero is detected.
- `hi_out` output WIDTH: remainder, registered.
- `lo_out` output WIDTH: quotient, registered.

## Operation
- States are IDLE, RUN, FIX.
- IDLE with `DivOp`=1 and `divisor`!=0:
  - latch |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend);
  - clear the partial remainder; count=0; go to RUN.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - Compute trial = rem - |divisor| at WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quotient bit = 1; otherwise rem is kept and the bit is 0.
  - After WIDTH steps (count reaches WIDTH-1), go to FIX.
- FIX:
  - `lo_out` = sign_q ? -quo : quo; `hi_out` = sign_r ? -rem : rem;
  - pulse `div_end`; go to IDLE.
- Truncating division semantics: the remainder has the sign of the dividend, and |rem| < |divisor|.
- Absolute values are taken as unsigned WIDTH-bit values, so |0x80000000| = 0x80000000.
- Overflow case 0x80000000 / 0xFFFFFFFF gives `lo_out` = 0x80000000 and `hi_out` = 0, with no flag.
- `DivOp` in RUN or FIX is ignored; it is neither queued nor restarts the operation.
- Operands are captured at start, so later changes to `dividend`/`divisor` do not affect the result.
- `hi_out`/`lo_out` change only in FIX and otherwise hold their last result.

## Timing
- Reset (asynchronous assert of `reset_in`=0, any state):
  - state = IDLE;
  - `div_busy`, `div_end`, `div_zero` = 0;
  - `hi_out`, `lo_out` = 0;
  - count and internal registers = 0.
- Reset release is used synchronously; the first start is accepted on the first rising edge with `reset_in`=1.
- `DivOp` sampled high at edge N:
  - `div_busy` is high from after edge N;
  - RUN steps occur at edges N+1..N+WIDTH;
  - FIX occurs at edge N+WIDTH+1;
  - `hi_out`, `lo_out` and `div_end` are valid after edge N+33 (WIDTH=32);
  - `div_end` and `div_busy` drop at edge N+34.
- Back-to-back: `DivOp` may be high in the cycle `div_end` is high. The unit is in IDLE then, so it accepts the new start at edge N+34.
- Reset mid-RUN aborts the operation; no `div_end` is produced.

## Configuration
- `DIV_ZERO_EXC_EN` defined:
  - IDLE with `DivOp`=1 and `divisor`=0 stays in IDLE and pulses `div_zero` for one cycle after that edge;
  - `hi_out`/`lo_out` are unchanged and `div_end` is not asserted.
- `DIV_ZERO_EXC_EN` undefined:
  - `div_zero` is tied to 0;
  - a zero divisor runs the normal 33-cycle sequence;
  - the result is that of the restoring algorithm: for a non-negative dividend, `lo_out` = 0xFFFFFFFF and `hi_out` = dividend.

## Test plan
- Positive operands: dividend=7, divisor=2, start at edge N -> `div_end` high after edge N+33, `lo_out`=3, `hi_out`=1, `div_busy` low after edge N+34.
- Mixed signs: -7 (0xFFFFFFF9) / 2 -> `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF. Also 7 / -2 -> `lo_out`=0xFFFFFFFD, `hi_out`=1.
- Overflow: 0x80000000 / 0xFFFFFFFF -> `lo_out`=0x80000000, `hi_out`=0, `div_zero`=0.
- Divide by zero with `DIV_ZERO_EXC_EN`: 5 / 0 -> `div_zero`=1 for exactly one cycle, `div_busy` stays 0, prior `hi_out`/`lo_out` unchanged. Without the macro: `lo_out`=0xFFFFFFFF, `hi_out`=5 at N+33.
- Busy / restart:
  - `DivOp` re-pulsed at N+10 with new operands -> ignored; the result is from the original operands.
  - A new `DivOp` in the `div_end` cycle -> accepted; the second result arrives 33 edges later.
- Reset mid-operation: `reset_in`=0 asynchronously at N+10 -> all outputs read 0 immediately, before the next edge; no `div_end` follows. A subsequent 100/7 gives `lo_out`=14, `hi_out`=2.
